ntps_axi_lite_regs: RTL and testbench
=====================================

# ntps_axi_lite_regs

AXI4-Lite responder plus register bank. Terminates one slave port of the PCIe-AXI bridge's 12-port master bus, selected by port index. Gives host software coherent 64-bit reads of the NTP time, a control word and a scratch register. Intended as the reusable register front end for new NTP-server sub-blocks that hang off the bridge next to the NTP clocks.

## Interface
Parameters:
- ADDR_WIDTH, 5: byte-address bits used; register index = addr[4:2], addr[1:0] ignored
- CORE_NAME, 32'h6e747073 ("ntps"): value of the NAME register
- CORE_VERSION, 32'h00010000: value of the VERSION register
- CTRL_RESET, 32'h0: reset value of CTRL

Ports:
- axi_aclk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- axi_awaddr  in  ADDR_WIDTH  write address
- axi_awprot  in  3  ignored
- axi_awvalid / axi_awready  in/out  1  write-address handshake
- axi_wdata  in  32  write data
- axi_wstrb  in  4  byte enables
- axi_wvalid / axi_wready  in/out  1  write-data handshake
- axi_bresp  out  2  write response
- axi_bvalid / axi_bready  out/in  1  write-response handshake
- axi_araddr  in  ADDR_WIDTH  read address
- axi_arprot  in  3  ignored
- axi_arvalid / axi_arready  in/out  1  read-address handshake
- axi_rdata  out  32  read data
- axi_rresp  out  2  read response
- axi_rvalid / axi_rready  out/in  1  read-data handshake
- ntp_time  in  64  live NTP time, {seconds, fraction}
- status  in  32  live status word
- ctrl  out  32  CTRL register contents
- ctrl_upd  out  1  one-cycle pulse after any accepted CTRL write

## Operation
Register map, by index:
- 0 NAME (RO)
- 1 VERSION (RO)
- 2 CTRL (RW, wstrb honoured)
- 3 STATUS (RO, live)
- 4 TIME_HI (RO): returns ntp_time[63:32] and, in the same cycle, latches ntp_time[31:0] into the snapshot
- 5 TIME_LO (RO): returns the snapshot
- 6 SCRATCH (RW, wstrb honoured)
- 7 unmapped: reads return 0 with SLVERR (2'b10); writes have no effect and return SLVERR

Response rules:
- All other accesses return OKAY (2'b00).
- Writes to RO registers are silently dropped and return OKAY.

Write FSM (WR_IDLE, WR_ACK, WR_RESP):
- WR_IDLE → WR_ACK when axi_awvalid and axi_wvalid are both high. One valid alone never advances the FSM.
- In WR_ACK, axi_awready = axi_wready = 1 for exactly one cycle. The register update happens on this edge.
- WR_ACK → WR_RESP. axi_bvalid stays high until axi_bready.
- WR_RESP → WR_IDLE on the bready handshake.

Read FSM (RD_IDLE, RD_ACK, RD_DATA):
- RD_IDLE → RD_ACK on axi_arvalid.
- In RD_ACK, axi_arready = 1 for one cycle. axi_rdata and axi_rresp are registered on this edge.
- RD_ACK → RD_DATA. axi_rvalid stays high, with rdata/rresp stable, until axi_rready.
- RD_DATA → RD_IDLE on the rready handshake.

Concurrency:
- One outstanding transaction per direction.
- The read and write FSMs are fully independent.
- If a read and a write to the same register are accepted in the same cycle, the read returns the pre-write value.

## Timing
- Reset values (the cycle after reset is sampled high):
  - all ready/valid outputs 0
  - axi_bresp, axi_rresp, axi_rdata 0
  - ctrl = CTRL_RESET
  - ctrl_upd 0
  - SCRATCH and snapshot 0
  - both FSMs in IDLE
- Write latency: valids high at cycle N → awready/wready at N+1 → bvalid at N+2 → ctrl/ctrl_upd visible at N+2. ctrl_upd is high for cycle N+2 only.
- Read latency: arvalid at N → arready at N+1 → rvalid with data at N+2.
- Back-to-back: the next transaction in a direction is accepted no earlier than 1 cycle after that direction's response handshake.
- Reset mid-transaction: reset wins. Pending bvalid/rvalid drop on the next edge with no response issued, and no register write takes effect in a WR_ACK cycle coinciding with reset.
- TIME coherence: TIME_LO returns the value latched by the most recent TIME_HI read, regardless of intervening writes or reads of other registers.

## Structure
- Shared package ntps_axi_pkg holds:
  - register index constants (ADDR_NAME … ADDR_SCRATCH)
  - response codes (RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10)
  - write and read FSM state encodings
- No sub-module; the block is flat.

## Test plan
- Reset: after reset, read CTRL → rdata = CTRL_RESET, rresp 00. Read NAME → 32'h6e747073.
- Byte-masked write: write CTRL 32'hAABBCCDD with wstrb 4'b0101 over CTRL = 0 → CTRL = 32'h00BB00DD, ctrl_upd pulses once at N+2, bresp 00.
- Split AW/W: awvalid at cycle 0, wvalid at cycle 5 → awready/wready only at cycle 6, bvalid at 7. Hold bready low 4 cycles → bvalid held, no second write accepted.
- Coherent time: ntp_time = 64'h0000_0001_FFFF_FFFF. Read TIME_HI → 1. Change ntp_time to 64'h0000_0002_0000_0000, then read TIME_LO → 32'hFFFF_FFFF.
- Unmapped index 7: read → rdata 0, rresp 10. Write → bresp 10, no register changes.
- Reset during RD_DATA with rready low: rvalid = 0 on the next cycle. A subsequent read of SCRATCH (previously written 32'h12345678) returns 0.

Source files
------------

// File: rtl/ntps_axi_pkg.sv
// ntps_axi_pkg
// Shared definitions for the NTP-server AXI4-Lite register front end:
//   - register index constants (index = byte address [4:2])
//   - AXI response codes
//   - write and read FSM state encodings
//   - byte-enable merge helper used by the RW registers
package ntps_axi_pkg;

    localparam logic [2:0] ADDR_NAME     = 3'd0;
    localparam logic [2:0] ADDR_VERSION  = 3'd1;
    localparam logic [2:0] ADDR_CTRL     = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_TIME_HI  = 3'd4;
    localparam logic [2:0] ADDR_TIME_LO  = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH  = 3'd6;
    localparam logic [2:0] ADDR_UNMAPPED = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ACK  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ntps_axi_lite_regs.sv
// ntps_axi_lite_regs
// AXI4-Lite responder and register bank for one slave port of the PCIe-AXI
// bridge. Provides NAME/VERSION identification, a CTRL word (with update
// pulse), live STATUS, a coherent 64-bit NTP time read (TIME_HI snapshots
// the low word, TIME_LO returns the snapshot) and a SCRATCH register.
//
// Handshake semantics: every channel transfers on a cycle where both valid
// and ready are high at the rising edge. This responder raises awready and
// wready together for exactly one cycle once both awvalid and wvalid are
// seen, raises arready for one cycle after arvalid, and holds bvalid/rvalid
// (with stable payload) until the matching bready/rready.
//
// Ports:
//   axi_aclk, reset            clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*      AXI4-Lite write address/data/response
//   axi_ar*/axi_r*             AXI4-Lite read address/data
//   ntp_time                   live NTP time {seconds, fraction}
//   status                     live status word
//   ctrl, ctrl_upd             CTRL contents and one-cycle update pulse
module ntps_axi_lite_regs
    import ntps_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter logic [31:0] CORE_NAME    = 32'h6e747073,
    parameter logic [31:0] CORE_VERSION = 32'h00010000,
    parameter logic [31:0] CTRL_RESET   = 32'h0
) (
    input  logic                  axi_aclk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [2:0]            axi_awprot,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic [63:0]           ntp_time,
    input  logic [31:0]           status,
    output logic [31:0]           ctrl,
    output logic                  ctrl_upd
);

    wr_state_t   r_wr_state;
    wr_state_t   w_wr_next;
    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;

    logic [31:0] r_ctrl;
    logic        r_ctrl_upd;
    logic [31:0] r_scratch;
    logic [31:0] r_snap;
    logic [1:0]  r_bresp;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    logic [2:0]  w_wr_idx;
    logic [2:0]  w_rd_idx;
    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;

    // Protection bits and the byte-offset bits carry no meaning here.
    logic        w_unused;
    assign w_unused = ^{axi_awprot, axi_arprot, axi_awaddr, axi_araddr};

    assign w_wr_idx  = axi_awaddr[4:2];
    assign w_rd_idx  = axi_araddr[4:2];
    assign w_wr_fire = (r_wr_state == WR_ACK);
    assign w_rd_fire = (r_rd_state == RD_ACK);

    // ---------------- write FSM ----------------
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            r_wr_state <= WR_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_IDLE: if (axi_awvalid && axi_wvalid) w_wr_next = WR_ACK;
            WR_ACK:  w_wr_next = WR_RESP;
            WR_RESP: if (axi_bready) w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (r_wr_state)
            WR_ACK: begin
                axi_awready = 1'b1;
                axi_wready  = 1'b1;
            end
            WR_RESP: axi_bvalid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (axi_arvalid) w_rd_next = RD_ACK;
            RD_ACK:  w_rd_next = RD_DATA;
            RD_DATA: if (axi_rready) w_rd_next = RD_IDLE;
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        case (r_rd_state)
            RD_ACK:  axi_arready = 1'b1;
            RD_DATA: axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- register bank: write side ----------------
    // Updates land on the WR_ACK edge; a coincident reset takes priority.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            r_ctrl     <= CTRL_RESET;
            r_ctrl_upd <= 1'b0;
            r_scratch  <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_ctrl_upd <= 1'b0;
            if (w_wr_fire) begin
                r_bresp <= (w_wr_idx == ADDR_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
                if (w_wr_idx == ADDR_CTRL) begin
                    r_ctrl     <= apply_wstrb(r_ctrl, axi_wdata, axi_wstrb);
                    r_ctrl_upd <= 1'b1;
                end
                if (w_wr_idx == ADDR_SCRATCH) begin
                    r_scratch <= apply_wstrb(r_scratch, axi_wdata, axi_wstrb);
                end
            end
        end
    end

    // ---------------- register bank: read side ----------------
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_idx)
            ADDR_NAME:    w_rd_data = CORE_NAME;
            ADDR_VERSION: w_rd_data = CORE_VERSION;
            ADDR_CTRL:    w_rd_data = r_ctrl;
            ADDR_STATUS:  w_rd_data = status;
            ADDR_TIME_HI: w_rd_data = ntp_time[63:32];
            ADDR_TIME_LO: w_rd_data = r_snap;
            ADDR_SCRATCH: w_rd_data = r_scratch;
            default:      w_rd_resp = RESP_SLVERR;
        endcase
    end

    // Read data is captured on the RD_ACK edge, so a write landing on the
    // same edge is not yet visible. A TIME_HI read freezes the fraction word
    // so the following TIME_LO read pairs with the same instant.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_snap  <= '0;
        end else if (w_rd_fire) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
            if (w_rd_idx == ADDR_TIME_HI) begin
                r_snap <= ntp_time[31:0];
            end
        end
    end

    assign axi_bresp = r_bresp;
    assign axi_rdata = r_rdata;
    assign axi_rresp = r_rresp;
    assign ctrl      = r_ctrl;
    assign ctrl_upd  = r_ctrl_upd;

endmodule

// File: tb/tb_ntps_axi_lite_regs.sv
// tb_ntps_axi_lite_regs
// Self-checking bench for ntps_axi_lite_regs: directed scenarios followed by
// randomized read/write traffic, checked against a register-map model.
module tb_ntps_axi_lite_regs;

    localparam logic [31:0] NAME_V    = 32'h6e747073;
    localparam logic [31:0] VERSION_V = 32'h00010000;
    localparam logic [31:0] CTRL_RST  = 32'h0;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [63:0] ntp_time;
    logic [31:0] status;
    logic [31:0] ctrl;
    logic        ctrl_upd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ntps_axi_lite_regs #(
        .ADDR_WIDTH   (5),
        .CORE_NAME    (NAME_V),
        .CORE_VERSION (VERSION_V),
        .CTRL_RESET   (CTRL_RST)
    ) dut (
        .axi_aclk    (clk),
        .reset       (reset),
        .axi_awaddr  (awaddr),
        .axi_awprot  (awprot),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arprot  (arprot),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .ntp_time    (ntp_time),
        .status      (status),
        .ctrl        (ctrl),
        .ctrl_upd    (ctrl_upd)
    );

    // ---------------- scoreboard / model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          check_en = 1'b0;
    logic [31:0] m_ctrl;
    logic [31:0] m_scratch;
    logic [31:0] m_snap;
    bit          exp_upd;
    logic [33:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl    = CTRL_RST;
        m_scratch = 32'h0;
        m_snap    = 32'h0;
        exp_upd   = 1'b0;
        exp_q.delete();
    endfunction

    // Returns {rresp, rdata} for a read accepted now.
    function automatic logic [33:0] model_read(input int idx);
        logic [33:0] r;
        r = {2'b00, 32'h0};
        case (idx)
            0: r[31:0] = NAME_V;
            1: r[31:0] = VERSION_V;
            2: r[31:0] = m_ctrl;
            3: r[31:0] = status;
            4: begin
                r[31:0] = ntp_time[63:32];
                m_snap  = ntp_time[31:0];
            end
            5: r[31:0] = m_snap;
            6: r[31:0] = m_scratch;
            default: r = {2'b10, 32'h0};
        endcase
        return r;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (idx == 2) m_ctrl    = (m_ctrl & ~mask) | (d & mask);
        if (idx == 6) m_scratch = (m_scratch & ~mask) | (d & mask);
    endfunction

    // Continuous compare of the CTRL outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ctrl", {32'h0, ctrl}, {32'h0, m_ctrl});
            chk("ctrl_upd", {63'h0, ctrl_upd}, {63'h0, exp_upd});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        repeat (cycles - 1) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs();
        @(negedge clk);
        chk("rst_awready", {63'h0, awready}, 64'h0);
        chk("rst_wready",  {63'h0, wready},  64'h0);
        chk("rst_bvalid",  {63'h0, bvalid},  64'h0);
        chk("rst_arready", {63'h0, arready}, 64'h0);
        chk("rst_rvalid",  {63'h0, rvalid},  64'h0);
        chk("rst_bresp",   {62'h0, bresp},   64'h0);
        chk("rst_rresp",   {62'h0, rresp},   64'h0);
        chk("rst_rdata",   {32'h0, rdata},   64'h0);
    endtask

    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                            input int split, input bit w_first, input int bdly, input bit hold);
        logic [1:0] eresp;
        logic [4:0] a;
        a = {idx[2:0], 2'b00};
        eresp = (idx == 7) ? 2'b10 : 2'b00;
        @(posedge clk); #1;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        if (split == 0) begin
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end else begin
            if (w_first) wvalid = 1'b1;
            else         awvalid = 1'b1;
            repeat (split) begin
                @(negedge clk);
                chk("aw_single_valid", {62'h0, awready, wready}, 64'h0);
                @(posedge clk); #1;
            end
            awvalid = 1'b1;
            wvalid  = 1'b1;
        end
        @(negedge clk);
        chk("aw_early", {62'h0, awready, wready}, 64'h0);
        @(negedge clk);
        chk("aw_hs", {62'h0, awready, wready}, 64'h3);
        chk("bvalid_early", {63'h0, bvalid}, 64'h0);
        @(posedge clk); #1;
        if (!hold) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
        model_write(idx, d, s);
        exp_upd = (idx == 2);
        @(negedge clk);
        chk("bvalid", {63'h0, bvalid}, 64'h1);
        chk("bresp", {62'h0, bresp}, {62'h0, eresp});
        @(posedge clk); #1;
        exp_upd = 1'b0;
        repeat (bdly) begin
            @(negedge clk);
            chk("bvalid_hold", {63'h0, bvalid}, 64'h1);
            chk("aw_blocked", {62'h0, awready, wready}, 64'h0);
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", {63'h0, bvalid}, 64'h0);
    endtask

    task automatic do_read(input int idx, input int rdly,
                           output logic [31:0] d, output logic [1:0] r);
        logic [33:0] e;
        @(posedge clk); #1;
        araddr  = {idx[2:0], 2'b00};
        arvalid = 1'b1;
        @(negedge clk);
        chk("ar_early", {63'h0, arready}, 64'h0);
        @(negedge clk);
        chk("ar_hs", {63'h0, arready}, 64'h1);
        chk("rvalid_early", {63'h0, rvalid}, 64'h0);
        exp_q.push_back(model_read(idx));
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("rvalid", {63'h0, rvalid}, 64'h1);
        chk("rdata", {32'h0, rdata}, {32'h0, e[31:0]});
        chk("rresp", {62'h0, rresp}, {62'h0, e[33:32]});
        d = rdata;
        r = rresp;
        repeat (rdly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rvalid_hold", {63'h0, rvalid}, 64'h1);
            chk("rdata_hold", {32'h0, rdata}, {32'h0, e[31:0]});
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_drop", {63'h0, rvalid}, 64'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic [31:0] rd_d2;
    logic [1:0]  rd_r2;

    initial begin
        reset    = 1'b0;
        awaddr   = '0;
        awprot   = '0;
        awvalid  = 1'b0;
        wdata    = '0;
        wstrb    = '0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        araddr   = '0;
        arprot   = '0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        ntp_time = 64'h0;
        status   = 32'h5a5a_0001;
        model_reset();

        do_reset(3);
        check_en = 1'b1;
        check_idle_outputs();

        // Reset contents.
        do_read(2, 0, rd_d, rd_r);
        chk("lit_ctrl_reset", {30'h0, rd_r, rd_d}, {30'h0, 2'b00, CTRL_RST});
        do_read(0, 1, rd_d, rd_r);
        chk("lit_name", {32'h0, rd_d}, 64'h6e747073);
        do_read(1, 0, rd_d, rd_r);
        do_read(3, 0, rd_d, rd_r);

        // Byte-masked CTRL write.
        do_write(2, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 0, 1'b0);
        chk("lit_ctrl_masked", {32'h0, ctrl}, 64'h00BB00DD);

        // Split AW/W arrival, bready held off with valids still asserted.
        do_write(6, 32'hCAFE0001, 4'hF, 5, 1'b0, 4, 1'b1);
        do_write(2, 32'h11223344, 4'b1010, 3, 1'b1, 2, 1'b0);
        chk("lit_ctrl_split", {32'h0, ctrl}, 64'h11BB33DD);

        // Coherent time read.
        ntp_time = 64'h0000_0001_FFFF_FFFF;
        do_read(4, 0, rd_d, rd_r);
        chk("lit_time_hi", {32'h0, rd_d}, 64'h1);
        ntp_time = 64'h0000_0002_0000_0000;
        do_read(3, 0, rd_d, rd_r);
        do_write(5, 32'h0BAD0BAD, 4'hF, 0, 1'b0, 0, 1'b0);
        do_read(5, 2, rd_d, rd_r);
        chk("lit_time_lo", {32'h0, rd_d}, 64'hFFFF_FFFF);

        // Unmapped index.
        do_read(7, 0, rd_d, rd_r);
        chk("lit_unmapped_rd", {30'h0, rd_r, rd_d}, {30'h0, 2'b10, 32'h0});
        do_write(7, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1, 1'b0);
        do_read(6, 0, rd_d, rd_r);
        chk("lit_scratch_kept", {32'h0, rd_d}, 64'hCAFE0001);

        // Write to a read-only register is dropped with OKAY.
        do_write(0, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
        do_read(0, 0, rd_d, rd_r);

        // Read and write of the same register accepted on the same edge.
        fork
            do_write(6, 32'h55AA55AA, 4'hF, 0, 1'b0, 0, 1'b0);
            do_read(6, 0, rd_d, rd_r);
        join
        chk("lit_pre_write", {32'h0, rd_d}, 64'hCAFE0001);
        do_read(6, 0, rd_d, rd_r);

        // Reset while rvalid is pending.
        do_write(6, 32'h12345678, 4'hF, 0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        araddr  = 5'd24;
        arvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rd_ar_hs", {63'h0, arready}, 64'h1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rst_rd_rvalid", {31'h0, rvalid, rdata}, {31'h0, 1'b1, 32'h12345678});
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_rvalid_drop", {63'h0, rvalid}, 64'h0);
        do_read(6, 0, rd_d, rd_r);
        chk("lit_scratch_after_rst", {32'h0, rd_d}, 64'h0);

        // Reset coinciding with the WR_ACK cycle: the write must not land.
        do_write(2, 32'hFFFF0000, 4'hF, 0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        awaddr  = 5'd24;
        wdata   = 32'hDEADBEEF;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wr_ack", {62'h0, awready, wready}, 64'h3);
        @(posedge clk); #1;
        model_reset();
        reset   = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        chk("rst_wr_bvalid", {63'h0, bvalid}, 64'h0);
        do_read(6, 0, rd_d, rd_r);
        chk("lit_scratch_no_wr", {32'h0, rd_d}, 64'h0);
        do_read(2, 0, rd_d, rd_r);
        chk("lit_ctrl_reset2", {32'h0, rd_d}, {32'h0, CTRL_RST});

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            int op;
            int wi;
            int ri;
            ntp_time = {$urandom, $urandom};
            status   = $urandom;
            op = $urandom_range(0, 2);
            wi = $urandom_range(0, 7);
            ri = $urandom_range(0, 7);
            if (op == 0) begin
                do_write(wi, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else if (op == 1) begin
                do_read(ri, $urandom_range(0, 3), rd_d, rd_r);
            end else begin
                fork
                    do_write(wi, $urandom, 4'($urandom_range(0, 15)), 0, 1'b0,
                             $urandom_range(0, 3), 1'b0);
                    do_read(ri, $urandom_range(0, 3), rd_d2, rd_r2);
                join
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
